// File: rtl/agg_buffer_reader_if.sv
// Command, buffer read-port and output-stream signals of agg_buffer_reader.
// The master modport is the reader; the slave modport is its environment.
interface agg_buffer_reader_if #(
  parameter int unsigned BUFFER_ADDR_WIDTH = 11,
  parameter int unsigned BUFFER_DATA_WIDTH = 512,
  parameter int unsigned LEN_WIDTH         = 12
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [BUFFER_ADDR_WIDTH-1:0] cmd_start_addr;
  logic [LEN_WIDTH-1:0]         cmd_len;

  logic                         agg_read_addr_valid;
  logic [BUFFER_ADDR_WIDTH-1:0] agg_read_addr;
  logic                         agg_read_data_valid;
  logic [BUFFER_DATA_WIDTH-1:0] agg_read_data;

  logic                         out_valid;
  logic                         out_ready;
  logic [BUFFER_DATA_WIDTH-1:0] out_data;
  logic                         out_last;

  logic                         busy;
  logic                         done;
  logic                         err;

  modport master (
    input  cmd_valid, cmd_start_addr, cmd_len,
    input  agg_read_data_valid, agg_read_data,
    input  out_ready,
    output cmd_ready,
    output agg_read_addr_valid, agg_read_addr,
    output out_valid, out_data, out_last,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_start_addr, cmd_len,
    output agg_read_data_valid, agg_read_data,
    output out_ready,
    input  cmd_ready,
    input  agg_read_addr_valid, agg_read_addr,
    input  out_valid, out_data, out_last,
    input  busy, done, err
  );
endinterface

// File: rtl/agg_buffer_reader.sv
// Read-side initiator for the aggregation feature buffer: issues credit-limited
// row reads, captures fixed-latency returns in a FWFT FIFO, streams them out.
module agg_buffer_reader #(
  parameter int unsigned BUFFER_ADDR_WIDTH = 11,
  parameter int unsigned BUFFER_DATA_WIDTH = 512,
  parameter int unsigned READ_LATENCY      = 4,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned LEN_WIDTH         = 12
) (
  input logic                 clk,
  input logic                 rst,
  agg_buffer_reader_if.master bus
);
  localparam int unsigned AW = BUFFER_ADDR_WIDTH;
  localparam int unsigned DW = BUFFER_DATA_WIDTH;
  localparam int unsigned LW = LEN_WIDTH;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_depth_check
    $error("FIFO_DEPTH must be at least READ_LATENCY+2 for full-rate issue");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_start;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_issued;
  logic [LW-1:0]   r_popped;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_fifo_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [DW-1:0]   r_mem [FIFO_DEPTH];

  logic            r_cmd_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_addr_valid;
  logic [AW-1:0]   r_addr;
  logic            r_out_valid;
  logic            r_out_last;
  logic [DW-1:0]   r_out_data;

  logic            w_accept;
  logic            w_credit;
  logic            w_issue;
  logic [AW-1:0]   w_issue_addr;
  logic            w_done_nxt;
  logic            w_pop;
  logic            w_full;
  logic            w_ret_ok;
  logic            w_push;
  logic            w_err_set;
  logic            w_finish;
  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_outst_nxt;
  logic [LW-1:0]   w_popped_nxt;
  logic [PW-1:0]   w_rd_ptr_inc;
  logic [DW-1:0]   w_head_data;

  assign w_accept     = bus.cmd_valid && r_cmd_ready;
  assign w_pop        = r_out_valid && bus.out_ready;
  assign w_finish     = w_pop && r_out_last;
  assign w_full       = (r_fifo_count == CW'(FIFO_DEPTH));
  assign w_ret_ok     = bus.agg_read_data_valid && (r_outstanding != '0);
  assign w_push       = w_ret_ok && !w_full;
  assign w_err_set    = bus.agg_read_data_valid && ((r_outstanding == '0) || w_full);
  assign w_rd_ptr_inc = r_rd_ptr + PW'(1);

  // Registered counts only: a pop this cycle frees its credit next cycle.
  assign w_credit = ({1'b0, r_outstanding} + {1'b0, r_fifo_count}) < SW'(FIFO_DEPTH);

  // Next state, issue decision and done pulse.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_addr = r_start + AW'(r_issued);
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.cmd_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_ISSUE;
            w_issue      = w_credit;
            w_issue_addr = bus.cmd_start_addr;
          end
        end
      end
      S_ISSUE: begin
        if (r_issued != r_len) begin
          w_issue = w_credit;
        end
        if ((r_issued + LW'(w_issue)) == r_len) begin
          w_state_nxt = S_DRAIN;
        end
        if (w_finish) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_finish) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counter next values and the head entry the stream presents next cycle.
  always_comb begin
    w_count_nxt = r_fifo_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_fifo_count + CW'(1);
      2'b01:   w_count_nxt = r_fifo_count - CW'(1);
      default: w_count_nxt = r_fifo_count;
    endcase

    w_outst_nxt = r_outstanding;
    case ({w_issue, w_ret_ok})
      2'b10:   w_outst_nxt = r_outstanding + CW'(1);
      2'b01:   w_outst_nxt = r_outstanding - CW'(1);
      default: w_outst_nxt = r_outstanding;
    endcase

    if (r_state == S_IDLE && w_accept) begin
      w_popped_nxt = '0;
    end else begin
      w_popped_nxt = r_popped + LW'(w_pop);
    end

    w_head_data = r_out_data;
    if (w_pop) begin
      w_head_data = (r_fifo_count == CW'(1)) ? bus.agg_read_data : r_mem[w_rd_ptr_inc];
    end else if (r_fifo_count == '0) begin
      w_head_data = bus.agg_read_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_addr_valid  <= 1'b0;
      r_addr        <= '0;
      r_start       <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_popped      <= '0;
      r_outstanding <= '0;
      r_fifo_count  <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_data    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= (w_state_nxt == S_IDLE);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= w_done_nxt;
      r_addr_valid  <= w_issue;
      r_addr        <= w_issue ? w_issue_addr : '0;
      r_outstanding <= w_outst_nxt;
      r_fifo_count  <= w_count_nxt;
      r_popped      <= w_popped_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (r_state == S_IDLE && w_accept) begin
        r_start  <= bus.cmd_start_addr;
        r_len    <= bus.cmd_len;
        r_issued <= LW'(w_issue);
      end else if (w_issue) begin
        r_issued <= r_issued + LW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      // out_last tracks the popped-row index of whatever sits at the head.
      r_out_valid <= (w_count_nxt != '0);
      r_out_last  <= (w_count_nxt != '0) && (w_popped_nxt == (r_len - LW'(1)));
      r_out_data  <= w_head_data;
    end
  end

  // Row storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.agg_read_data;
    end
  end

  assign bus.cmd_ready           = r_cmd_ready;
  assign bus.busy                = r_busy;
  assign bus.done                = r_done;
  assign bus.err                 = r_err;
  assign bus.agg_read_addr_valid = r_addr_valid;
  assign bus.agg_read_addr       = r_addr;
  assign bus.out_valid           = r_out_valid;
  assign bus.out_last            = r_out_last;
  assign bus.out_data            = r_out_data;

endmodule

// File: tb/tb_agg_buffer_reader.sv
// Self-checking bench for agg_buffer_reader: fixed-latency buffer model,
// queue-based expected row stream, table of commands plus directed corners.
module tb_agg_buffer_reader;
  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 512;
  localparam int unsigned LW    = 12;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  agg_buffer_reader_if #(.BUFFER_ADDR_WIDTH(AW), .BUFFER_DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  agg_buffer_reader #(
    .BUFFER_ADDR_WIDTH(AW), .BUFFER_DATA_WIDTH(DW), .READ_LATENCY(LAT),
    .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW+1:0] act, input logic [DW+1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Buffer model: fixed latency, data = zero-extended row address.
  logic [LAT-1:0] pv;
  logic [AW-1:0]  pa [LAT];
  logic           inj = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pa[i] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], bus.agg_read_addr_valid};
      pa[0] <= bus.agg_read_addr;
      for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    end
  end
  assign bus.agg_read_data_valid = pv[LAT-1] | inj;
  assign bus.agg_read_data       = DW'(pa[LAT-1]);

  // Reference: expected address stream and expected {last,data} row stream.
  logic [AW-1:0] exp_addr_q [$];
  logic [DW:0]   exp_row_q  [$];
  int n_addr, n_pop, n_done, n_outv, first_addr, last_addr, first_out, last_out, done_cyc;
  logic          hold_p = 1'b0;
  logic [DW:0]   hold_v;

  task automatic clear_stats();
    n_addr = 0; n_pop = 0; n_done = 0; n_outv = 0;
    first_addr = -1; last_addr = -1; first_out = -1; last_out = -1; done_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_p = 1'b0;
    end else begin
      if (bus.agg_read_addr_valid) begin
        n_addr++;
        if (first_addr < 0) first_addr = cyc;
        last_addr = cyc;
        chk("addr_expected", (DW+2)'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) chk("addr", (DW+2)'(bus.agg_read_addr), (DW+2)'(exp_addr_q.pop_front()));
      end else begin
        chk("addr_idle_zero", (DW+2)'(bus.agg_read_addr), 0);
      end
      if (hold_p) chk("stream_hold", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, hold_v});
      if (bus.out_valid) begin
        n_outv++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (bus.out_ready) begin
          n_pop++;
          chk("row_expected", (DW+2)'(exp_row_q.size() > 0), 1);
          if (exp_row_q.size() > 0) chk("row", {1'b0, bus.out_last, bus.out_data}, {1'b0, exp_row_q.pop_front()});
        end
      end
      hold_p = bus.out_valid && !bus.out_ready;
      hold_v = {bus.out_last, bus.out_data};
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = held low while rdy_hold.
  int   rdy_mode = 0;
  logic rdy_hold = 1'b0;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = !rdy_hold;
      endcase
    end
  end

  task automatic start_cmd(input logic [AW-1:0] st, input logic [LW-1:0] ln, input int mode, output int acc);
    int t;
    for (int i = 0; i < int'(ln); i++) begin
      logic [AW-1:0] a;
      a = st + AW'(i);
      exp_addr_q.push_back(a);
      exp_row_q.push_back({(i == int'(ln) - 1), DW'(a)});
    end
    rdy_mode = mode;
    clear_stats();
    t = 0;
    @(negedge clk); #1;
    while (!bus.cmd_ready && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk("cmd_ready_idle", (DW+2)'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1; bus.cmd_start_addr = st; bus.cmd_len = ln;
    acc = cyc;
    @(negedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("ready_k1", (DW+2)'(bus.cmd_ready), (DW+2)'(ln == 0));
    chk("busy_k1",  (DW+2)'(bus.busy),      (DW+2)'(ln != 0));
    chk("done_k1",  (DW+2)'(bus.done),      (DW+2)'(ln == 0));
  endtask

  task automatic finish_cmd(input logic [LW-1:0] ln, input int acc, input int done_rel,
                            input int out_rel, input bit contig);
    int t = 0;
    while (n_done == 0 && t < 4000) begin
      @(negedge clk); #1;
      t++;
    end
    repeat (3) begin @(negedge clk); #1; end
    chk("done_once",   (DW+2)'(n_done), 1);
    chk("addr_count",  (DW+2)'(n_addr), (DW+2)'(ln));
    chk("pop_count",   (DW+2)'(n_pop),  (DW+2)'(ln));
    chk("queues_empty", (DW+2)'(exp_addr_q.size() + exp_row_q.size()), 0);
    chk("idle_after",  (DW+2)'({bus.cmd_ready, bus.busy, bus.err}), 3'b100);
    if (ln != 0) chk("first_addr_cycle", (DW+2)'(first_addr - acc), 1);
    if (done_rel >= 0) chk("done_cycle", (DW+2)'(done_cyc - acc), (DW+2)'(done_rel));
    if (out_rel >= 0) chk("first_out_cycle", (DW+2)'(first_out - acc), (DW+2)'(out_rel));
    if (contig) begin
      chk("addr_contig", (DW+2)'(last_addr - first_addr + 1), (DW+2)'(ln));
      chk("out_contig",  (DW+2)'(last_out - first_out + 1),   (DW+2)'(ln));
      chk("out_cycles",  (DW+2)'(n_outv), (DW+2)'(ln));
    end
  endtask

  typedef struct {
    logic [AW-1:0] st;
    logic [LW-1:0] ln;
    int            mode;
    int            done_rel;
    int            out_rel;
    bit            contig;
  } vec_t;
  vec_t tbl [7];

  initial begin
    int acc;
    tbl[0] = '{11'h010, 12'd4,  0, 10, 6, 1'b1};
    tbl[1] = '{11'h000, 12'd64, 0, 70, 6, 1'b1};
    tbl[2] = '{11'h7FE, 12'd4,  0, 10, 6, 1'b1};
    tbl[3] = '{11'h000, 12'd0,  0, 1, -1, 1'b0};
    tbl[4] = '{11'h123, 12'd1,  0, 7,  6, 1'b1};
    tbl[5] = '{11'h5A5, 12'd17, 1, -1, -1, 1'b0};
    tbl[6] = '{11'h7F0, 12'd40, 1, -1, -1, 1'b0};

    bus.cmd_valid = 1'b0; bus.cmd_start_addr = '0; bus.cmd_len = '0;
    clear_stats();
    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.agg_read_addr_valid,
                          bus.out_valid, bus.out_last}, 7'b1000000);
    chk("reset_addr", (DW+2)'(bus.agg_read_addr), 0);
    chk("reset_data", (DW+2)'(bus.out_data), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      start_cmd(tbl[i].st, tbl[i].ln, tbl[i].mode, acc);
      finish_cmd(tbl[i].ln, acc, tbl[i].done_rel, tbl[i].out_rel, tbl[i].contig);
    end

    // Backpressure: credit allows exactly DEPTH requests with nothing popped.
    rdy_hold = 1'b1;
    start_cmd(11'h200, 12'd32, 2, acc);
    repeat (30) begin @(negedge clk); #1; end
    chk("bp_issue_stall", (DW+2)'(n_addr), (DW+2)'(DEPTH));
    chk("bp_out_valid", (DW+2)'(bus.out_valid), 1);
    rdy_hold = 1'b0;
    finish_cmd(12'd32, acc, -1, -1, 1'b0);

    // Randomized commands against the queue model.
    for (int i = 0; i < 14; i++) begin
      logic [AW-1:0] st;
      logic [LW-1:0] ln;
      int            md;
      st = AW'($urandom);
      ln = LW'($urandom_range(0, 40));
      md = $urandom_range(0, 1);
      start_cmd(st, ln, md, acc);
      finish_cmd(ln, acc, (md == 0) ? ((ln == 0) ? 1 : int'(ln) + LAT + 2) : -1,
                 (md == 0 && ln != 0) ? LAT + 2 : -1, (md == 0 && ln != 0));
    end

    // Reset mid-ISSUE with three requests outstanding.
    start_cmd(11'h100, 12'd20, 0, acc);
    for (int t = 0; t < 50 && n_addr < 3; t++) begin @(negedge clk); #1; end
    chk("three_issued", (DW+2)'(n_addr), 3);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.agg_read_addr_valid,
                           bus.out_valid, bus.out_last}, 7'b1000000);
    chk("midrst_addr", (DW+2)'(bus.agg_read_addr), 0);
    exp_addr_q.delete();
    exp_row_q.delete();
    clear_stats();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) begin @(negedge clk); #1; end
    chk("no_done_after_rst", (DW+2)'(n_done), 0);
    chk("no_addr_after_rst", (DW+2)'(n_addr), 0);
    start_cmd(11'h3F0, 12'd2, 0, acc);
    finish_cmd(12'd2, acc, 8, 6, 1'b1);

    // Spurious return while idle sets a sticky error.
    @(negedge clk); inj = 1'b1;
    @(negedge clk); inj = 1'b0;
    #1;
    chk("err_set", (DW+2)'(bus.err), 1);
    chk("err_no_push", (DW+2)'(bus.out_valid), 0);
    repeat (5) begin @(negedge clk); #1; end
    chk("err_sticky", (DW+2)'(bus.err), 1);
    rst = 1'b1;
    #1;
    chk("err_cleared", (DW+2)'(bus.err), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/agg_buffer_reader.md
Name: agg_buffer_reader

Overview:
Read-side initiator for the single-port aggregation feature buffer. It accepts a command with a start row and a row count, and issues one read address per cycle to the buffer's agg read port. Returned rows come back at a fixed latency and are captured in a small first-word-fall-through FIFO. The rows are then presented to the aggregation datapath on a valid/ready stream. Because the buffer read port has no backpressure, issue is credit-limited so that returning data can never overflow the FIFO.

Parameters:
BUFFER_ADDR_WIDTH, 11, buffer row address width; addresses wrap modulo 2^BUFFER_ADDR_WIDTH
BUFFER_DATA_WIDTH, 512, row width in bits
READ_LATENCY, 4, cycles from an addr-valid cycle to the matching data-valid cycle of the buffer
FIFO_DEPTH, 8, return FIFO entries; power of 2; must be >= READ_LATENCY+2 for full rate
LEN_WIDTH, 12, width of the row-count field

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  high only in IDLE
cmd_start_addr  in  BUFFER_ADDR_WIDTH  first row
cmd_len  in  LEN_WIDTH  rows to read; 0 = no-op
agg_read_addr_valid  out  1  read request to buffer (registered)
agg_read_addr  out  BUFFER_ADDR_WIDTH  read row (registered; 0 when not valid)
agg_read_data_valid  in  1  buffer return valid
agg_read_data  in  BUFFER_DATA_WIDTH  buffer return data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_data  out  BUFFER_DATA_WIDTH  row data
out_last  out  1  marks the final row of the command
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a command completes
err  out  1  sticky protocol error flag; cleared only by rst

Behaviour:
- Reset values: every output is 0 except cmd_ready, which is 1. All counters are 0, the FIFO is empty, and the FSM is in IDLE.
- Reset is asynchronous; assertion mid-command aborts it immediately with no done pulse. The buffer shares the same reset, so in-flight returns are discarded.
- FSM states:
  - IDLE: cmd_valid && cmd_ready at edge k. If cmd_len != 0, latch the start address and length, set issued = 0, go to ISSUE. If cmd_len == 0, stay in IDLE and pulse done in cycle k+1.
  - ISSUE: a read is issued at an edge when issued < len and outstanding + fifo_count < FIFO_DEPTH. The request is visible during the next cycle with agg_read_addr = start + issued, truncated to BUFFER_ADDR_WIDTH. When issued reaches len, go to DRAIN.
  - DRAIN: wait until all rows have been popped.
- Completion: the pop of the row carrying out_last returns the FSM to IDLE at that edge and pulses done in the following cycle. cmd_ready is high again in that same cycle.
- Issue timing: the first agg_read_addr_valid is high in cycle k+1. Consecutive issues are back-to-back, one row per cycle, whenever credit allows.
- outstanding: counts requests issued but not yet returned. It increments on issue and decrements on agg_read_data_valid; simultaneous events leave it unchanged.
- Credit rule: a pop in the current cycle does not free credit until the next cycle.
- Return path:
  - Data valid in cycle c+READ_LATENCY (c = request cycle) is written into the FIFO at the end of that cycle.
  - out_valid rises in cycle c+READ_LATENCY+1.
  - The FIFO is first-word-fall-through; simultaneous push and pop is allowed, including push and pop at the same time with count == FIFO_DEPTH-1.
- Stream rules:
  - out_data and out_last are held stable while out_valid && !out_ready.
  - out_last is set on the entry whose return index equals len-1. A popped-row counter is compared with len.
- Errors (err set, data dropped):
  - agg_read_data_valid arrives while outstanding == 0.
  - A push arrives when the FIFO is full.
  - Neither case is reachable with a correct buffer; both exist for checking.
- Widths: issued and popped counters are LEN_WIDTH bits. outstanding and fifo_count are clog2(FIFO_DEPTH)+1 bits.

Test Plan:
- Single command, start 0x010, len 4, out_ready=1, buffer model READ_LATENCY=4 returning addr as data -> addresses 0x010..0x013 in cycles k+1..k+4; out_valid in cycles k+6..k+9 with data 0x10..0x13; out_last on 0x13; done in k+10.
- Full rate, start 0, len 64, out_ready=1 -> 64 consecutive addr-valid cycles with no bubbles; 64 contiguous out_valid cycles; err=0.
- Backpressure, len 32, out_ready held 0 -> exactly 8 requests issued and then issue stalls; out_ready=1 resumes issue; all 32 rows arrive in order; done once.
- Wrap, start 0x7FE, len 4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001.
- len=0 command -> no agg_read_addr_valid; done in k+1; next command accepted in k+1.
- rst asserted mid-ISSUE with 3 rows outstanding -> all outputs return to reset values asynchronously; no done pulse; a following command len 2 completes normally. A separate directed run injects agg_read_data_valid while idle -> err=1 and stays 1 until rst.
